// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage. This stage owns the fetch PC, issues reads to a
// synchronous instruction ROM and buffers (pc, instr) pairs in a small FIFO.
// Decode takes the pairs over a valid/ready handshake.
//
// A redirect empties the FIFO, drops any in-flight read and reloads the PC.
// The issue rule counts buffered entries plus in-flight reads against the
// FIFO depth, so a returning read always has a free slot.
//
// Optional feature: when IF_MISALIGN_TRAP_EN is defined, a misaligned
// redirect target is kept as-is and its head entry is flagged on
// out_misalign. Fetching then stops until the next redirect or reset.
// Without the macro, redirect targets are word-aligned and out_misalign
// is tied low.
module inst_fetch_stage #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     IMEM_AW    = 8,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [31:0]        out_instr,
  output logic               out_misalign
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic [XLEN-1:0] load_pc;
  logic            inflight;
  logic            push;
  logic            pop;
  logic            stall;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   occupancy;

  logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0]     fifo_instr [FIFO_DEPTH];

`ifdef IF_MISALIGN_TRAP_EN
  logic halted;

  assign load_pc      = redirect_pc;
  assign stall        = halted;
  assign out_misalign = |out_pc[1:0];

  // Stop fetching after the misaligned PC has been issued once; a redirect or reset resumes.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      halted <= 1'b0;
    end else if (imem_req && (|fetch_pc[1:0])) begin
      halted <= 1'b1;
    end
  end
`else
  assign load_pc      = redirect_pc & ~XLEN'(3);
  assign stall        = 1'b0;
  assign out_misalign = 1'b0;
`endif

  // The occupancy counts entries already buffered plus the read in flight,
  // minus the entry decode takes this cycle.
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight && !redirect && !reset;
  assign occupancy = count + CW'(inflight) - CW'(pop);
  assign imem_req  = !reset && !redirect && !stall && (occupancy < CW'(FIFO_DEPTH));
  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;
  assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;

  // Control state: PC, in-flight tracking and FIFO pointers; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= load_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + XLEN'(4);
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: the ROM response and its issuing PC are written together.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= inflight_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  // The issue rule must keep a push from ever landing in a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage (XLEN=32, IMEM_AW=8, FIFO_DEPTH=2).
// The ROM model returns its own word address as data: ROM[i] = i.
module tb_inst_fetch_stage;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;

  int unsigned checks = 0;
  int unsigned errors = 0;

  inst_fetch_stage #(
    .XLEN       (32),
    .RESET_PC   (32'h0),
    .IMEM_AW    (8),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_misalign (out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: ROM[i] = i, data valid the cycle after the request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle, apply the inputs for that cycle, let them settle.
  task automatic step(input logic rst, input logic rd, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    reset       = rst;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr, input logic mis);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      check({tag, ".pc"}, out_pc, pc);
      check({tag, ".instr"}, out_instr, instr);
      check({tag, ".misalign"}, 32'(out_misalign), 32'(mis));
    end
  endtask

  task automatic expect_req(input string tag, input logic r, input logic [7:0] addr);
    check({tag, ".req"}, 32'(imem_req), 32'(r));
    if (r) check({tag, ".addr"}, 32'(imem_addr), 32'(addr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;

    // Reset state
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.req", 32'(imem_req), 32'd0);
    check("rst.pc", out_pc, 32'h0);
    check("rst.instr", out_instr, 32'h0);
    check("rst.misalign", 32'(out_misalign), 32'd0);

    // Streaming from reset: request in cycle 0, output from cycle 2, no bubbles
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      expect_req($sformatf("run%0d", k), 1'b1, 8'(k));
      expect_out($sformatf("run%0d", k), k >= 2, 32'((k - 2) * 4), 32'(k - 2), 1'b0);
    end

    // Back-pressure: head holds at 0x20, fetching stops once the buffer is full
    for (int k = 10; k < 20; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      expect_req($sformatf("bp%0d", k), 1'b0, 8'h0);
      expect_out($sformatf("bp%0d", k), 1'b1, 32'h20, 32'h8, 1'b0);
    end

    // Release: sequence resumes without loss or duplicate
    for (int k = 20; k < 24; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      expect_req($sformatf("rel%0d", k), 1'b1, 8'(8 + k - 20 + 2));
      expect_out($sformatf("rel%0d", k), 1'b1, 32'(32'h20 + (k - 20) * 4), 32'(8 + k - 20), 1'b0);
    end

    // Redirect to 0x40 with one buffered entry and a read in flight
    step(1'b0, 1'b1, 32'h40, 1'b0);
    expect_req("rd0", 1'b0, 8'h0);
    expect_out("rd0", 1'b1, 32'h30, 32'hC, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_req("rd1", 1'b1, 8'h10);
    expect_out("rd1", 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_req("rd2", 1'b1, 8'h11);
    expect_out("rd2", 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("rd3", 1'b1, 32'h40, 32'h10, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("rd4", 1'b1, 32'h44, 32'h11, 1'b0);

    // PC wrap: 0xFFFF_FFFC then 0x0
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    expect_req("wr0", 1'b0, 8'h0);
    expect_out("wr0", 1'b1, 32'h48, 32'h12, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_req("wr1", 1'b1, 8'hFF);
    expect_out("wr1", 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_req("wr2", 1'b1, 8'h00);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("wr3", 1'b1, 32'hFFFF_FFFC, 32'hFF, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("wr4", 1'b1, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("wr5", 1'b1, 32'h4, 32'h1, 1'b0);

    // Mid-stream reset together with a redirect: reset wins, refetch from RESET_PC
    step(1'b1, 1'b1, 32'h80, 1'b1);
    expect_req("mr0", 1'b0, 8'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_req("mr1", 1'b1, 8'h00);
    expect_out("mr1", 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_req("mr2", 1'b1, 8'h01);
    expect_out("mr2", 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("mr3", 1'b1, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("mr4", 1'b1, 32'h4, 32'h1, 1'b0);

    // Misaligned redirect target 0x42
    step(1'b0, 1'b1, 32'h42, 1'b1);
    expect_req("ma0", 1'b0, 8'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_req("ma1", 1'b1, 8'h10);
    expect_out("ma1", 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("ma2", 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef IF_MISALIGN_TRAP_EN
    expect_req("ma2", 1'b0, 8'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("ma3", 1'b1, 32'h42, 32'h10, 1'b1);
    for (int k = 4; k < 8; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      expect_req($sformatf("ma%0d", k), 1'b0, 8'h0);
      expect_out($sformatf("ma%0d", k), 1'b0, 32'h0, 32'h0, 1'b0);
    end
`else
    expect_req("ma2", 1'b1, 8'h11);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("ma3", 1'b1, 32'h40, 32'h10, 1'b0);
    for (int k = 4; k < 8; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      expect_req($sformatf("ma%0d", k), 1'b1, 8'(16 + k - 1));
      expect_out($sformatf("ma%0d", k), 1'b1, 32'(32'h40 + (k - 3) * 4), 32'(16 + k - 3), 1'b0);
    end
`endif

    // A following aligned redirect resumes fetching in either build
    step(1'b0, 1'b1, 32'h80, 1'b1);
    expect_req("rs0", 1'b0, 8'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_req("rs1", 1'b1, 8'h20);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("rs3", 1'b1, 32'h80, 32'h20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
